// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//
// Round sequencer for an iterative AES-128 encryption datapath. It accepts a
// plaintext block over a valid/ready handshake. It then walks the external
// round datapath through the initial AddRoundKey and NR full rounds, fetching
// one round key per step from the key-expansion unit over a req/ack
// handshake. Completion is offered to the consumer over a second valid/ready
// handshake. No 128-bit data lives here; only control signals leave.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   inValid    in   a plaintext block is present at the datapath input
//   inReady    out  controller is idle and can take a block
//   stateLoad  out  datapath loads its input into the state register
//   keyReq     out  request for round key keyIdx
//   keyIdx     out  index of the requested round key (same as roundNum)
//   keyAck     in   requested key is valid on the key bus this cycle
//   stateEn    out  datapath applies one round and writes the state register
//   roundNum   out  current round, 0..NR
//   bypassSub  out  skip SubBytes and ShiftRows (round 0)
//   bypassMix  out  skip MixColumns (round 0 and the final round)
//   outValid   out  ciphertext is stable in the datapath state register
//   outReady   in   consumer takes the ciphertext
//   busy       out  a block is in flight (KEYWAIT or DONE)
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inValid,
    output logic       inReady,
    output logic       stateLoad,
    output logic       keyReq,
    output logic [3:0] keyIdx,
    input  logic       keyAck,
    output logic       stateEn,
    output logic [3:0] roundNum,
    output logic       bypassSub,
    output logic       bypassMix,
    output logic       outValid,
    input  logic       outReady,
    output logic       busy
);

    // Last round index as a 4-bit constant, so compares against roundNum
    // are width-matched.
    localparam logic [3:0] LastRound = 4'(NR);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEYWAIT = 2'd1,
        DONE    = 2'd2
    } stateT;

    stateT state;

    // Main sequencer. The handshake outputs inReady, keyReq, outValid and busy
    // are registered here alongside the state, so each one equals a decode of
    // the state register. None of them has a path from an input.
    // IDLE accepts a block and resets the round count. KEYWAIT advances one
    // round per acknowledged key and leaves after the final round. DONE holds
    // the result until the consumer takes it. roundNum keeps its last value
    // through DONE and IDLE and is only cleared by the next accept, so it
    // never exceeds NR and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            roundNum <= 4'd0;
            inReady  <= 1'b1;
            keyReq   <= 1'b0;
            outValid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        state    <= KEYWAIT;
                        roundNum <= 4'd0;
                        inReady  <= 1'b0;
                        keyReq   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                KEYWAIT: begin
                    if (keyAck) begin
                        if (roundNum == LastRound) begin
                            state    <= DONE;
                            keyReq   <= 1'b0;
                            outValid <= 1'b1;
                        end else begin
                            roundNum <= roundNum + 4'd1;
                        end
                    end
                end
                DONE: begin
                    // Returning to IDLE takes a full cycle. A block offered
                    // during the outReady handshake is taken on the next cycle.
                    if (outReady) begin
                        state    <= IDLE;
                        outValid <= 1'b0;
                        busy     <= 1'b0;
                        inReady  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    roundNum <= 4'd0;
                    inReady  <= 1'b1;
                    keyReq   <= 1'b0;
                    outValid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Handshake strobes into the datapath. Each is a registered output gated
    // by one input, so the datapath sees the transfer in the same cycle.
    assign stateLoad = inValid & inReady;
    assign stateEn   = keyReq & keyAck;

    // Key index and stage bypasses follow roundNum at all times. The datapath
    // only uses them while keyReq is high. Round 0 is the bare initial
    // AddRoundKey. The final round omits MixColumns.
    assign keyIdx    = roundNum;
    assign bypassSub = (roundNum == 4'd0);
    assign bypassMix = (roundNum == 4'd0) || (roundNum == LastRound);

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the iterative AES-128 encryption datapath. It accepts a block through a valid/ready handshake, steps the external round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey) through the initial AddRoundKey plus NR rounds, and fetches one round key per step from the key-expansion unit over a req/ack handshake. It presents completion through a second valid/ready handshake. It owns no 128-bit data; it drives only control into the datapath's state register and stage bypass muxes.

## Interface
- NR, 10: number of full rounds after the initial AddRoundKey; legal range 1..15.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inValid  in  1  a plaintext block is present on the datapath input.
- inReady  out  1  the controller can accept a block (state IDLE).
- stateLoad  out  1  datapath captures its input into the state register (= inValid & inReady).
- keyReq  out  1  request for round key keyIdx.
- keyIdx  out  4  index of the requested round key (= roundNum).
- keyAck  in  1  the requested key is valid on the datapath key bus during this cycle.
- stateEn  out  1  datapath applies one round and writes the state register (= keyReq & keyAck).
- roundNum  out  4  current round, 0..NR.
- bypassSub  out  1  datapath skips SubBytes and ShiftRows (roundNum == 0).
- bypassMix  out  1  datapath skips MixColumns (roundNum == 0 or roundNum == NR).
- outValid  out  1  ciphertext is stable in the datapath state register.
- outReady  in  1  the consumer takes the ciphertext.
- busy  out  1  the controller is in KEYWAIT or DONE.

## Operation
- FSM states: IDLE, KEYWAIT, DONE. Encode them in 2 bits. roundNum is a 4-bit register.
- IDLE
  - inReady = 1.
  - On inValid: assert stateLoad, clear roundNum to 0, go to KEYWAIT.
- KEYWAIT
  - keyReq = 1 continuously; it never drops before keyAck.
  - On keyAck: assert stateEn for that cycle.
  - If roundNum == NR, go to DONE and hold roundNum.
  - Otherwise increment roundNum and stay in KEYWAIT.
  - Without keyAck, hold state and roundNum. Stalls of any length are legal.
- DONE
  - outValid = 1; hold until outReady.
  - On outReady, go to IDLE.
  - outValid falls in the cycle after the handshake.
- Outputs derived from state or roundNum:
  - inReady, keyReq, outValid and busy are decoded from the registered state, with no input-to-output path.
  - stateLoad and stateEn are combinational ANDs of a registered output with one input.
  - bypassSub and bypassMix are decoded from roundNum and valid only while keyReq is high. Outside KEYWAIT they still follow roundNum, and the datapath ignores them.
- roundNum never exceeds NR and never wraps. No increment occurs in IDLE or DONE.
- keyAck outside KEYWAIT is ignored. inValid outside IDLE is ignored and must be held by the producer.
- outReady outside DONE is ignored.
- A DONE→IDLE handshake cycle with inValid high does not accept the block. The block is accepted in the following cycle.

## Timing
- Reset, asynchronous:
  - state = IDLE, roundNum = 0.
  - inReady = 1, bypassSub = 1, bypassMix = 1.
  - keyReq = stateEn = stateLoad(with inValid=0) = outValid = busy = 0.
- Reset asserted mid-operation aborts immediately, with no outValid. The datapath content is don't-care.
- Accept in cycle T:
  - KEYWAIT covers T+1 .. T+1+NR+stalls.
  - With keyAck tied high, stateEn pulses in cycles T+1..T+NR+1 (11 pulses for NR = 10). keyIdx takes the values 0,1,…,10 in those cycles.
  - outValid rises at T+NR+2 (T+12).
- Minimum issue interval with outReady tied high: NR+3 cycles (13).
- Each keyAck stall cycle adds exactly one cycle of latency.

## Test plan
- Reset then idle:
  - Stimulus: hold rst_n low 3 cycles, release, inValid = 0 for 5 cycles.
  - Required response: inReady = 1, roundNum = 0, no keyReq/stateEn/outValid.
- Single block, keyAck and outReady tied high, NR = 10:
  - Stimulus: inValid in cycle 0.
  - Required response: stateLoad in cycle 0; stateEn in cycles 1–11 with keyIdx 0..10.
  - Bypass checks: bypassSub = 1 only at keyIdx 0; bypassMix = 1 at keyIdx 0 and 10.
  - outValid in cycle 12 only; inReady back at 13.
- Key stalls:
  - Stimulus: deassert keyAck for 2 cycles at round 0 and 3 cycles at round 5.
  - Required response: keyReq stays high and keyIdx holds across each stall. Exactly 11 stateEn pulses; outValid at cycle 17.
- Output backpressure:
  - Stimulus: outReady = 0 for 4 cycles after outValid rises, with inValid held high throughout.
  - Required response: outValid and roundNum = 10 held. No second accept until the cycle after the outReady handshake.
- Async reset at round 6:
  - Stimulus: drop rst_n mid-cycle during round 6.
  - Required response: keyReq falls without a clock edge; state IDLE, roundNum = 0. A new block afterwards completes normally.
- Back-to-back blocks, NR = 1 build:
  - Stimulus: inValid, keyAck and outReady all tied high.
  - Required response: accepts at cycles 0, 4, 8, … (interval NR+3 = 4); bypassMix = 1 on both keyIdx 0 and 1.
